// File: rtl/axi_rdata_router.sv
// axi_rdata_router: AXI read-data (R) channel interconnect.
// Routes R beats from NUM_S slave ports to NUM_M master ports. The destination
// master index is carried in the upper 4 bits of the slave-side RID.
// Each master port has a round-robin arbiter with burst locking and a 2-entry
// output register slice. When DEFAULT_SLAVE_EN is set, the last slave port is
// the default slave and its beats are returned with DECERR.
//
// Ports:
//   ACLK, ARESETn                      clock, asynchronous active-low reset
//   RID_S/RDATA_S/RRESP_S/RLAST_S      slave beats, slave s in slice s
//   RVALID_S / RREADY_S                slave handshake (RREADY_S is combinational)
//   RID_M/RDATA_M/RRESP_M/RLAST_M      master beats, head of each slice
//   RVALID_M / RREADY_M                master handshake (RVALID_M from slice state)
//   err_drop                           sticky: a beat addressed a nonexistent master
module axi_rdata_router #(
  parameter int unsigned NUM_M            = 2,
  parameter int unsigned NUM_S            = 3,
  parameter int unsigned ID_BITS          = 4,
  parameter int unsigned DATA_BITS        = 32,
  parameter bit          DEFAULT_SLAVE_EN = 1'b1
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [NUM_S*(ID_BITS+4)-1:0]      RID_S,
  input  logic [NUM_S*DATA_BITS-1:0]        RDATA_S,
  input  logic [NUM_S*2-1:0]                RRESP_S,
  input  logic [NUM_S-1:0]                  RLAST_S,
  input  logic [NUM_S-1:0]                  RVALID_S,
  output logic [NUM_S-1:0]                  RREADY_S,
  output logic [NUM_M*ID_BITS-1:0]          RID_M,
  output logic [NUM_M*DATA_BITS-1:0]        RDATA_M,
  output logic [NUM_M*2-1:0]                RRESP_M,
  output logic [NUM_M-1:0]                  RLAST_M,
  output logic [NUM_M-1:0]                  RVALID_M,
  input  logic [NUM_M-1:0]                  RREADY_M,
  output logic                              err_drop
);

  localparam int unsigned SID_BITS    = ID_BITS + 4;
  localparam int unsigned SW          = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int unsigned DEFAULT_IDX = NUM_S - 1;

  typedef struct packed {
    logic [ID_BITS-1:0]   id;
    logic [DATA_BITS-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } beat_t;

  beat_t            s_beat  [NUM_S];
  logic [3:0]       s_dest  [NUM_S];
  logic [NUM_S-1:0] s_drop;

  logic [NUM_S-1:0] req     [NUM_M];
  logic [SW-1:0]    gnt_idx [NUM_M];
  logic [SW-1:0]    rr_nxt  [NUM_M];
  beat_t            m_in    [NUM_M];
  logic [NUM_M-1:0] gnt_vld;
  logic [NUM_M-1:0] push;
  logic [NUM_M-1:0] pop;
  logic [NUM_M-1:0] full;

  beat_t            slot    [NUM_M][2];
  logic [1:0]       count   [NUM_M];
  logic [SW-1:0]    owner   [NUM_M];
  logic [SW-1:0]    rr      [NUM_M];
  logic [NUM_M-1:0] wr_ptr;
  logic [NUM_M-1:0] rd_ptr;
  logic [NUM_M-1:0] lock;

  // Slave-side decode: destination, stored payload (with DECERR override), drops.
  always_comb begin
    for (int unsigned s = 0; s < NUM_S; s++) begin
      s_dest[s]      = RID_S[s*SID_BITS+ID_BITS +: 4];
      s_beat[s].id   = RID_S[s*SID_BITS +: ID_BITS];
      s_beat[s].data = RDATA_S[s*DATA_BITS +: DATA_BITS];
      s_beat[s].resp = (DEFAULT_SLAVE_EN && (s == DEFAULT_IDX)) ? 2'b11 : RRESP_S[s*2 +: 2];
      s_beat[s].last = RLAST_S[s];
      s_drop[s]      = RVALID_S[s] && ({1'b0, s_dest[s]} >= 5'(NUM_M));
    end
  end

  // Per-master arbitration: owner only while locked, else round-robin from rr.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned m = 0; m < NUM_M; m++) begin
      full[m]    = (count[m] == 2'd2);
      gnt_vld[m] = 1'b0;
      gnt_idx[m] = '0;
      for (int unsigned s = 0; s < NUM_S; s++) begin
        req[m][s] = RVALID_S[s] && (s_dest[s] == 4'(m));
      end
      if (lock[m]) begin
        gnt_idx[m] = owner[m];
        gnt_vld[m] = req[m][owner[m]];
      end else begin
        // Scan from farthest to nearest so the first requester at/after rr wins.
        for (int unsigned k = NUM_S; k > 0; k--) begin
          idx = 32'(rr[m]) + k - 1;
          if (idx >= NUM_S) idx = idx - NUM_S;
          if (req[m][SW'(idx)]) begin
            gnt_vld[m] = 1'b1;
            gnt_idx[m] = SW'(idx);
          end
        end
      end
      rr_nxt[m] = (gnt_idx[m] == SW'(NUM_S - 1)) ? '0 : gnt_idx[m] + SW'(1);
      push[m]   = gnt_vld[m] && !full[m];
      pop[m]    = (count[m] != 2'd0) && RREADY_M[m];
      m_in[m]   = s_beat[gnt_idx[m]];
    end
  end

  // Slave ready: granted into a non-full slice, or discarded as a drop.
  always_comb begin
    logic [NUM_S-1:0] acc;
    acc = s_drop;
    for (int unsigned s = 0; s < NUM_S; s++) begin
      for (int unsigned m = 0; m < NUM_M; m++) begin
        if (push[m] && (gnt_idx[m] == SW'(s))) acc[s] = 1'b1;
      end
    end
    RREADY_S = acc & {NUM_S{ARESETn}};
  end

  // Slice storage, arbitration state and sticky drop flag.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_drop <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lock     <= '0;
      for (int unsigned m = 0; m < NUM_M; m++) begin
        count[m]   <= 2'd0;
        owner[m]   <= '0;
        rr[m]      <= '0;
        slot[m][0] <= '0;
        slot[m][1] <= '0;
      end
    end else begin
      if (|s_drop) err_drop <= 1'b1;
      for (int unsigned m = 0; m < NUM_M; m++) begin
        if (push[m]) begin
          slot[m][wr_ptr[m]] <= m_in[m];
          wr_ptr[m]          <= ~wr_ptr[m];
          if (m_in[m].last) begin
            lock[m] <= 1'b0;
            rr[m]   <= rr_nxt[m];
          end else begin
            lock[m]  <= 1'b1;
            owner[m] <= gnt_idx[m];
          end
        end
        if (pop[m]) rd_ptr[m] <= ~rd_ptr[m];
        case ({push[m], pop[m]})
          2'b10:   count[m] <= count[m] + 2'd1;
          2'b01:   count[m] <= count[m] - 2'd1;
          default: count[m] <= count[m];
        endcase
      end
    end
  end

  // Master outputs come straight from the slice head.
  always_comb begin
    RID_M    = '0;
    RDATA_M  = '0;
    RRESP_M  = '0;
    RLAST_M  = '0;
    RVALID_M = '0;
    for (int unsigned m = 0; m < NUM_M; m++) begin
      RVALID_M[m]                       = (count[m] != 2'd0);
      RID_M[m*ID_BITS +: ID_BITS]       = slot[m][rd_ptr[m]].id;
      RDATA_M[m*DATA_BITS +: DATA_BITS] = slot[m][rd_ptr[m]].data;
      RRESP_M[m*2 +: 2]                 = slot[m][rd_ptr[m]].resp;
      RLAST_M[m]                        = slot[m][rd_ptr[m]].last;
    end
  end

endmodule

// File: tb/tb_axi_rdata_router.sv
// Bench for axi_rdata_router (NUM_M=2, NUM_S=3, ID_BITS=4, DATA_BITS=32, default slave on).
module tb_axi_rdata_router;
  localparam int NM = 2;
  localparam int NS = 3;

  logic          ACLK;
  logic          ARESETn;
  logic [NS*8-1:0]  RID_S;
  logic [NS*32-1:0] RDATA_S;
  logic [NS*2-1:0]  RRESP_S;
  logic [NS-1:0]    RLAST_S;
  logic [NS-1:0]    RVALID_S;
  logic [NS-1:0]    RREADY_S;
  logic [NM*4-1:0]  RID_M;
  logic [NM*32-1:0] RDATA_M;
  logic [NM*2-1:0]  RRESP_M;
  logic [NM-1:0]    RLAST_M;
  logic [NM-1:0]    RVALID_M;
  logic [NM-1:0]    RREADY_M;
  logic             err_drop;

  axi_rdata_router #(.NUM_M(NM), .NUM_S(NS), .ID_BITS(4), .DATA_BITS(32), .DEFAULT_SLAVE_EN(1'b1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M), .err_drop(err_drop)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct packed { logic [7:0] rid; logic [31:0] data; logic [1:0] resp; logic last; } sbeat_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } mbeat_t;
  typedef struct packed { logic [NS-1:0] rs; logic [NM-1:0] vm; } logent_t;

  typedef struct {
    int          s;
    logic [7:0]  rid;
    logic [31:0] data;
    logic [1:0]  resp;
    int          exp_m;     // -1: beat is dropped
    logic [1:0]  exp_resp;
    logic        exp_err;
  } vec_t;

  // Reference model: per-slave send queues and per-(master,slave) expected beats.
  sbeat_t  sq  [NS][$];
  mbeat_t  exq [NM*NS][$];
  int      mlog [NM][$];
  logent_t lg [$];
  bit      pres [NS];
  bit      inb  [NM];
  int      cur  [NM];
  int      mrdy_pct [NM];
  bit      gap_en;
  bit      drop_exp;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_model();
    for (int s = 0; s < NS; s++) begin sq[s].delete(); pres[s] = 0; end
    for (int i = 0; i < NM*NS; i++) exq[i].delete();
    for (int m = 0; m < NM; m++) begin mlog[m].delete(); inb[m] = 0; cur[m] = 0; end
    lg.delete();
    drop_exp = 0;
  endtask

  task automatic do_reset();
    ARESETn  = 1'b0;
    RVALID_S = '0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '0;
    RREADY_M = '0;
    clear_model();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
  endtask

  // Enqueue a slave beat and record where the specification says it must land.
  task automatic send(input int s, input logic [7:0] rid, input logic [31:0] data,
                      input logic [1:0] resp, input logic last);
    sbeat_t b;
    mbeat_t e;
    int d;
    b.rid = rid; b.data = data; b.resp = resp; b.last = last;
    sq[s].push_back(b);
    d = int'(rid[7:4]);
    if (d >= NM) drop_exp = 1;
    else begin
      e.id = rid[3:0]; e.data = data; e.last = last;
      e.resp = (s == NS-1) ? 2'b11 : resp;
      exq[d*NS+s].push_back(e);
    end
  endtask

  function automatic bit all_done();
    all_done = 1;
    for (int s = 0; s < NS; s++) if (sq[s].size() != 0) all_done = 0;
    for (int i = 0; i < NM*NS; i++) if (exq[i].size() != 0) all_done = 0;
  endfunction

  // Master-side scoreboard: source slave is carried in data[31:28].
  task automatic capture(input int m);
    mbeat_t got, exp;
    int src;
    bit ok;
    got.id = RID_M[m*4 +: 4]; got.data = RDATA_M[m*32 +: 32];
    got.resp = RRESP_M[m*2 +: 2]; got.last = RLAST_M[m];
    src = int'(got.data[31:28]);
    mlog[m].push_back(src);
    ok = 0;
    if (src < NS) ok = (exq[m*NS+src].size() > 0);
    chk($sformatf("m%0d_beat_known", m), 64'(ok), 64'd1);
    if (ok) begin
      exp = exq[m*NS+src].pop_front();
      chk($sformatf("m%0d_beat", m), 64'(got), 64'(exp));
    end
    if (inb[m]) chk($sformatf("m%0d_burst_contig", m), 64'(src), 64'(cur[m]));
    cur[m] = src;
    inb[m] = !got.last;
  endtask

  // Cycle engine: called at posedge+1, drives AXI-compliant slaves and masters.
  task automatic run(input int ncyc, input bit until_done);
    bit took [NS];
    sbeat_t b;
    int c;
    c = 0;
    while (c < ncyc && !(until_done && all_done())) begin
      for (int s = 0; s < NS; s++) begin
        if (sq[s].size() > 0 && (pres[s] || !gap_en || $urandom_range(3) != 0)) begin
          b = sq[s][0];
          RID_S[s*8 +: 8] = b.rid; RDATA_S[s*32 +: 32] = b.data;
          RRESP_S[s*2 +: 2] = b.resp; RLAST_S[s] = b.last;
          RVALID_S[s] = 1'b1; pres[s] = 1;
        end else RVALID_S[s] = 1'b0;
      end
      for (int m = 0; m < NM; m++) RREADY_M[m] = ($urandom_range(99) < mrdy_pct[m]);
      #1;
      lg.push_back({RREADY_S, RVALID_M});
      for (int s = 0; s < NS; s++) took[s] = RVALID_S[s] && RREADY_S[s];
      for (int m = 0; m < NM; m++) if (RVALID_M[m] && RREADY_M[m]) capture(m);
      @(posedge ACLK); #1;
      for (int s = 0; s < NS; s++) if (took[s]) begin void'(sq[s].pop_front()); pres[s] = 0; end
      c++;
    end
    if (until_done) chk("drain_done", 64'(all_done()), 64'd1);
    RVALID_S = '0;
    RREADY_M = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tv [7];
  int exp_ord [7];

  initial begin
    n_pass = 0; n_total = 0; gap_en = 0;
    for (int m = 0; m < NM; m++) mrdy_pct[m] = 100;

    // Reset values, with slaves already requesting.
    ARESETn = 1'b0; RREADY_M = '1; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '1;
    RVALID_S = '1;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_rready_s", 64'(RREADY_S), 64'd0);
    chk("rst_rvalid_m", 64'(RVALID_M), 64'd0);
    chk("rst_rid_m", 64'(RID_M), 64'd0);
    chk("rst_rdata_m", 64'(RDATA_M), 64'd0);
    chk("rst_rresp_rlast", 64'({RRESP_M, RLAST_M}), 64'd0);
    chk("rst_err_drop", 64'(err_drop), 64'd0);

    // Single-beat vector table; drops last since err_drop is sticky.
    tv[0] = '{0, 8'h03, 32'hDEADBEEF, 2'b00,  0, 2'b00, 1'b0};
    tv[1] = '{1, 8'h1A, 32'h12345678, 2'b10,  1, 2'b10, 1'b0};
    tv[2] = '{2, 8'h05, 32'hCAFEF00D, 2'b00,  0, 2'b11, 1'b0};
    tv[3] = '{2, 8'h17, 32'h00000000, 2'b01,  1, 2'b11, 1'b0};
    tv[4] = '{1, 8'h0F, 32'hA5A55A5A, 2'b01,  0, 2'b01, 1'b0};
    tv[5] = '{0, 8'h5C, 32'h11111111, 2'b00, -1, 2'b00, 1'b1};
    tv[6] = '{1, 8'hF1, 32'h22222222, 2'b00, -1, 2'b00, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      RID_S[tv[i].s*8 +: 8] = tv[i].rid; RDATA_S[tv[i].s*32 +: 32] = tv[i].data;
      RRESP_S[tv[i].s*2 +: 2] = tv[i].resp; RLAST_S[tv[i].s] = 1'b1;
      RVALID_S = '0; RVALID_S[tv[i].s] = 1'b1; RREADY_M = '1;
      #1;
      chk($sformatf("tv%0d_rready_s", i), 64'(RREADY_S), 64'(1 << tv[i].s));
      @(posedge ACLK); #1;
      RVALID_S = '0;
      if (tv[i].exp_m < 0) begin
        chk($sformatf("tv%0d_rvalid_m", i), 64'(RVALID_M), 64'd0);
      end else begin
        chk($sformatf("tv%0d_rvalid_m", i), 64'(RVALID_M), 64'(1 << tv[i].exp_m));
        chk($sformatf("tv%0d_rid", i), 64'(RID_M[tv[i].exp_m*4 +: 4]), 64'(tv[i].rid[3:0]));
        chk($sformatf("tv%0d_rdata", i), 64'(RDATA_M[tv[i].exp_m*32 +: 32]), 64'(tv[i].data));
        chk($sformatf("tv%0d_rresp", i), 64'(RRESP_M[tv[i].exp_m*2 +: 2]), 64'(tv[i].exp_resp));
        chk($sformatf("tv%0d_rlast", i), 64'(RLAST_M[tv[i].exp_m]), 64'd1);
      end
      chk($sformatf("tv%0d_err_drop", i), 64'(err_drop), 64'(tv[i].exp_err));
      @(posedge ACLK); #1;
    end
    repeat (3) @(posedge ACLK);
    #1;
    chk("err_drop_sticky", 64'(err_drop), 64'd1);
    do_reset();
    chk("err_drop_cleared", 64'(err_drop), 64'd0);

    // Arbitration and burst lock: S0 burst beats S1, then rr favours S2 over S1.
    for (int k = 0; k < 4; k++) send(0, 8'h12, {4'h0, 28'(k)}, 2'b00, k == 3);
    send(1, 8'h1E, {4'h1, 28'h0000010}, 2'b01, 1'b1);
    run(40, 1);
    send(1, 8'h16, {4'h1, 28'h0000020}, 2'b00, 1'b1);
    send(2, 8'h18, {4'h2, 28'h0000030}, 2'b00, 1'b1);
    run(40, 1);
    exp_ord = '{0, 0, 0, 0, 1, 2, 1};
    chk("arb_m1_count", 64'(mlog[1].size()), 64'd7);
    for (int i = 0; i < 7 && i < mlog[1].size(); i++)
      chk($sformatf("arb_m1_order%0d", i), 64'(mlog[1][i]), 64'(exp_ord[i]));

    // Backpressure: 5 beats into a stalled M0 slice.
    do_reset();
    for (int k = 0; k < 5; k++) send(0, 8'h07, {4'h0, 28'(k)}, 2'b00, k == 4);
    mrdy_pct[0] = 0;
    run(6, 0);
    for (int c = 0; c < 6; c++)
      chk($sformatf("bp_rready_s0_c%0d", c), 64'(lg[c].rs[0]), 64'(c < 2));
    chk("bp_accepted", 64'(sq[0].size()), 64'd3);
    mrdy_pct[0] = 100;
    lg.delete();
    run(40, 1);
    chk("bp_release_c0", 64'(lg[0].rs[0]), 64'd0);
    chk("bp_release_c1", 64'(lg[1].rs[0]), 64'd1);
    chk("bp_m0_count", 64'(mlog[0].size()), 64'd5);

    // Parallel paths: independent masters both accept in one cycle.
    do_reset();
    send(0, 8'h01, {4'h0, 28'h0000ABC}, 2'b00, 1'b1);
    send(1, 8'h12, {4'h1, 28'h0000DEF}, 2'b00, 1'b1);
    run(2, 0);
    chk("par_rready_s", 64'(lg[0].rs), 64'b011);
    chk("par_rvalid_m", 64'(lg[1].vm), 64'b11);
    chk("par_done", 64'(all_done()), 64'd1);

    // Reset in the middle of a 4-beat burst.
    do_reset();
    for (int k = 0; k < 4; k++) send(0, 8'h04, {4'h0, 28'(k)}, 2'b00, k == 3);
    run(2, 0);
    chk("mid_pre_rvalid", 64'(RVALID_M[0]), 64'd1);
    RVALID_S[0] = 1'b1;
    ARESETn = 1'b0;
    #1;
    chk("mid_rvalid_m", 64'(RVALID_M), 64'd0);
    chk("mid_rready_s", 64'(RREADY_S), 64'd0);
    chk("mid_data_m", 64'({RID_M, RRESP_M, RLAST_M}), 64'd0);
    chk("mid_rdata_m", 64'(RDATA_M), 64'd0);
    clear_model();
    RVALID_S = '0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    send(1, 8'h0B, {4'h1, 28'h0000777}, 2'b00, 1'b1);
    run(20, 1);
    chk("mid_after_count", 64'(mlog[0].size()), 64'd1);

    // Randomized traffic against the scoreboard.
    do_reset();
    gap_en = 1;
    for (int m = 0; m < NM; m++) mrdy_pct[m] = $urandom_range(100, 40);
    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < 10; b++) begin
        int d, len;
        logic [3:0] id;
        d   = ($urandom_range(9) == 0) ? 5 : $urandom_range(1);
        len = $urandom_range(4, 1);
        id  = 4'($urandom);
        for (int k = 0; k < len; k++)
          send(s, {4'(d), id}, {4'(s), 28'($urandom)}, 2'($urandom), k == len-1);
      end
    end
    run(3000, 1);
    chk("rnd_err_drop", 64'(err_drop), 64'(drop_exp));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
